// File: rtl/gf_sqrt_iter.sv
// gf_sqrt_iter: iterative GF(2^M) square root.
// sqrt(a) = a^(2^(M-1)), computed as M-1 in-field squarings modulo POLY,
// SQ_PER_CYC squarings per clock, behind a start/busy/done handshake.
// Optional macro SQRT_SELFCHECK_EN adds a CHECK state that squares the
// result once more and flags err when it does not reproduce the operand.
module gf_sqrt_iter #(
  parameter int         M          = 8,
  parameter logic [M:0] POLY       = 9'h11B,
  parameter int         SQ_PER_CYC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] din,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] dout,
  output logic         err
);

  // Wide enough to hold M-1 and SQ_PER_CYC without wrapping.
  localparam int            RW       = $clog2(M) + 1;
  localparam logic [RW-1:0] REM_INIT = RW'(M - 1);
  localparam logic [RW-1:0] SQ_W     = RW'(SQ_PER_CYC);

`ifdef SQRT_SELFCHECK_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

  // Field squaring: spread a_i to bit 2i, then fold bits 2M-2..M back down
  // by XORing POLY aligned so its top bit cancels the bit being reduced.
  function automatic logic [M-1:0] gf_sq(input logic [M-1:0] a);
    logic [2*M-2:0] t;
    t = '0;
    for (int i = 0; i < M; i++) t[2*i] = a[i];
    for (int b = 2*M-2; b >= M; b--) begin
      if (t[b]) t[b-M +: M+1] = t[b-M +: M+1] ^ POLY;
    end
    return t[M-1:0];
  endfunction

  state_t        state_q, state_d;
  logic [M-1:0]  acc_q, acc_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [M-1:0]  dout_q, dout_d;
  logic          done_q, done_d;

  logic [M-1:0]  sq_chain [0:SQ_PER_CYC];
  logic [RW-1:0] step_k;
  logic [M-1:0]  sq_sel;

`ifdef SQRT_SELFCHECK_EN
  logic [M-1:0]  shadow_q, shadow_d;
  logic          err_q, err_d;
`endif

  // Squaring chain for one RUN cycle; the last cycle may need fewer steps.
  always_comb begin
    sq_chain[0] = acc_q;
    for (int j = 1; j <= SQ_PER_CYC; j++) sq_chain[j] = gf_sq(sq_chain[j-1]);
    step_k = (rem_q < SQ_W) ? rem_q : SQ_W;
    sq_sel = sq_chain[SQ_PER_CYC];
    for (int j = 1; j <= SQ_PER_CYC; j++) begin
      if (RW'(j) == step_k) sq_sel = sq_chain[j];
    end
  end

  // Next-state and datapath control.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned,
    // which is what would otherwise infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
`ifdef SQRT_SELFCHECK_EN
    shadow_d = shadow_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          acc_d   = din;
          rem_d   = REM_INIT;
          state_d = S_RUN;
`ifdef SQRT_SELFCHECK_EN
          shadow_d = din;
          err_d    = 1'b0;
`endif
        end
      end
      S_RUN: begin
        acc_d = sq_sel;
        rem_d = rem_q - step_k;
        if (rem_q == step_k) begin
`ifdef SQRT_SELFCHECK_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
          dout_d  = sq_sel;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef SQRT_SELFCHECK_EN
      S_CHECK: begin
        state_d = S_DONE;
        dout_d  = acc_q;
        done_d  = 1'b1;
        err_d   = (gf_sq(acc_q) != shadow_q);
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the accumulator and counter are ordinary registers, not memory,
    // so they are cleared with everything else; an abort leaves no residue.
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

`ifdef SQRT_SELFCHECK_EN
  // Shadow copy of the operand and the registered mismatch flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end
  assign err  = err_q;
  assign busy = (state_q == S_RUN) || (state_q == S_CHECK);
`else
  assign err  = 1'b0;
  assign busy = (state_q == S_RUN);
`endif

  assign done = done_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_gf_sqrt_iter.sv
// Directed bench for gf_sqrt_iter (M=8, POLY=0x11B), SQ_PER_CYC=1 and 3.
module tb_gf_sqrt_iter;

`ifdef SQRT_SELFCHECK_EN
  localparam int LAT1 = 9;
  localparam int LAT3 = 5;
`else
  localparam int LAT1 = 8;
  localparam int LAT3 = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start3;
  logic [7:0] din, din3;
  logic       busy, done, err, busy3, done3, err3;
  logic [7:0] dout, dout3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gf_sqrt_iter #(.M(8), .POLY(9'h11B), .SQ_PER_CYC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din),
    .busy(busy), .done(done), .dout(dout), .err(err)
  );

  gf_sqrt_iter #(.M(8), .POLY(9'h11B), .SQ_PER_CYC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .din(din3),
    .busy(busy3), .done(done3), .dout(dout3), .err(err3)
  );

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
    string      name;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference squarer: a*a by shift-and-add with xtime reduction by 0x1B.
  function automatic logic [7:0] model_sq(input logic [7:0] a);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  // One operation on the SQ_PER_CYC=1 instance; returns at the negedge of the
  // done cycle. lat counts posedges from the accepting edge through done.
  task automatic run_op(input logic [7:0] a, output logic [7:0] res,
                        output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1;
    din   = a;
    lat   = 0;
    bcnt  = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
      if (busy) bcnt++;
    end while (!done && lat < 40);
    res = dout;
  endtask

  task automatic run_op3(input logic [7:0] a, output logic [7:0] res, output int lat);
    @(negedge clk);
    start3 = 1'b1;
    din3   = a;
    lat    = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start3 = 1'b0;
    end while (!done3 && lat < 40);
    res = dout3;
  endtask

  initial begin
    logic [7:0] res;
    logic [7:0] a;
    int         lat, bcnt, seen;
    logic       hold_ok;

    vecs[0] = '{8'h04, 8'h02, "v04"};
    vecs[1] = '{8'h10, 8'h04, "v10"};
    vecs[2] = '{8'h40, 8'h08, "v40"};
    vecs[3] = '{8'h1B, 8'h10, "v1B"};
    vecs[4] = '{8'h6C, 8'h20, "v6C"};
    vecs[5] = '{8'h00, 8'h00, "v00"};
    vecs[6] = '{8'h01, 8'h01, "v01"};
    vecs[7] = '{8'h05, 8'h03, "v05"};
    vecs[8] = '{8'h55, 8'h0F, "v55"};
    vecs[9] = '{8'hAB, 8'h40, "vAB"};

    rst_n  = 1'b0;
    start  = 1'b0;
    din    = 8'h00;
    start3 = 1'b0;
    din3   = 8'h00;

    #12;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst dout", dout, 8'h00);
    check("rst err",  err,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    foreach (vecs[i]) begin
      run_op(vecs[i].din, res, lat, bcnt);
      check({vecs[i].name, " dout"}, res, vecs[i].dout);
      check({vecs[i].name, " lat"},  lat, LAT1);
      check({vecs[i].name, " busy cycles"}, bcnt, LAT1 - 1);
      check({vecs[i].name, " err"},  err, 1'b0);
    end

    // Done lasts exactly one cycle.
    @(negedge clk);
    check("done pulse width", done, 1'b0);
    check("dout held in DONE", dout, 8'h40);

    // Start held with din changing while busy: first capture wins.
    @(negedge clk);
    start = 1'b1;
    din   = 8'h04;
    lat   = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      din = din + 8'h11;
      if (lat >= 4) start = 1'b0;
    end while (!done && lat < 40);
    check("held start dout", dout, 8'h02);
    check("held start lat",  lat,  LAT1);

    // Back-to-back: start during the done cycle of a previous operation.
    run_op(8'h10, res, lat, bcnt);
    check("b2b first dout", res, 8'h04);
    start = 1'b1;
    din   = 8'h40;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b busy rises", busy, 1'b1);
    check("b2b done drops", done, 1'b0);
    lat     = 1;
    hold_ok = 1'b1;
    while (!done && lat < 40) begin
      if (dout !== 8'h04) hold_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("b2b dout held", hold_ok, 1'b1);
    check("b2b second dout", dout, 8'h08);
    check("b2b second lat",  lat,  LAT1);

    // Reset mid-RUN aborts with no done afterwards.
    @(negedge clk);
    start = 1'b1;
    din   = 8'h04;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort dout", dout, 8'h00);
    check("abort err",  err,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("abort no done", seen, 0);
    run_op(8'h6C, res, lat, bcnt);
    check("post-abort dout", res, 8'h20);
    check("post-abort lat",  lat, LAT1);

    // SQ_PER_CYC=3: squarings split 3+3+1.
    run_op3(8'h6C, res, lat);
    check("sq3 6C dout", res, 8'h20);
    check("sq3 6C lat",  lat, LAT3);
    check("sq3 6C err",  err3, 1'b0);
    run_op3(8'hAB, res, lat);
    check("sq3 AB dout", res, 8'h40);
    check("sq3 AB lat",  lat, LAT3);

    // Random operands: squaring the result must give the operand back.
    for (int r = 0; r < 1000; r++) begin
      a = 8'($urandom_range(0, 255));
      run_op(a, res, lat, bcnt);
      check("rand sq(dout)", model_sq(res), a);
      check("rand err", err, 1'b0);
      check("rand lat", lat, LAT1);
    end

`ifdef SQRT_SELFCHECK_EN
    // Corrupt the accumulator mid-RUN: the final result is off by one bit.
    @(negedge clk);
    start = 1'b1;
    din   = 8'h04;
    lat   = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
      if (lat == 4) force u_dut.acc_q = 8'h03;
    end while (!done && lat < 40);
    check("flip err on done", err, 1'b1);
    check("flip dout", dout, 8'h03);
    release u_dut.acc_q;
    @(negedge clk);
    start = 1'b1;
    din   = 8'h10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("flip err cleared", err, 1'b0);
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("flip recovery dout", dout, 8'h04);
    check("flip recovery err",  err,  1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gf_sqrt_iter.md
Name: gf_sqrt_iter

Overview:
- Iterative GF(2^M) square-root unit, the inverse operation of the combinational squarer used in the Itoh-Tsuji inversion datapath.
- Computes sqrt(a) = a^(2^(M-1)) by repeated in-field squaring modulo POLY.
- Uses a start/busy/done handshake. Result is held until the next accepted start.
- Used by inversion/verification logic that needs to undo squarings or check squarer outputs.

Parameters:
- M, 8, field degree; operand width in bits.
- POLY, 9'h11B, irreducible reduction polynomial, M+1 bits, bit M must be 1.
- SQ_PER_CYC, 1, squarings applied per clock in RUN; legal range 1..M-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- din  input  M  operand a, captured on accepted start.
- busy  output  1  high while computing (RUN, and CHECK when compiled in).
- done  output  1  one-cycle pulse when dout becomes valid.
- dout  output  M  sqrt(din), valid from the done cycle until the next accepted start.
- err  output  1  self-check mismatch flag; tied 0 unless SQRT_SELFCHECK_EN.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, dout=0, err=0, internal accumulator and counter cleared.
- Reset asserted mid-operation aborts immediately. No done is produced for the aborted operation.
- States:
  - IDLE: start=1 -> load acc=din, rem=M-1, goto RUN, busy=1 next cycle.
  - RUN: each cycle acc <= acc squared k times, where k=min(SQ_PER_CYC, rem); rem <= rem-k. When rem-k==0: goto DONE (or CHECK if compiled in), dout <= final acc, done=1 for that next cycle, busy=0.
  - DONE: dout held. start=1 behaves exactly as in IDLE (back-to-back allowed; done pulses then busy rises the following cycle). start=0 -> stay DONE.
- start while busy=1 is ignored; din is not re-sampled.
- Latency from accepted start to done: ceil((M-1)/SQ_PER_CYC) RUN cycles, plus 1. M=8, SQ_PER_CYC=1 gives done 8 cycles after the start edge.
- Squaring is generic: spread bits a_i -> position 2i (2M-1 bits), then reduce bits 2M-2 down to M by XORing POLY shifted into place. Pure GF(2) XOR logic, no carries.
- dout is registered. done is registered and never held high for more than 1 cycle.
- din==0 -> dout=0; din==1 -> dout=1. These take the full latency; there is no fast path.

Optional Feature:
- Macro: SQRT_SELFCHECK_EN.
- When defined:
  - Captured din is kept in a shadow register.
  - After RUN, an extra CHECK state squares the result once and compares it to the shadow.
  - err <= (mismatch), updated in the same cycle as done.
  - err is cleared on the next accepted start.
  - Latency grows by 1 cycle; busy stays high through CHECK.
- When undefined: no shadow register, no CHECK state, err constant 0, latency as above.

Test Plan:
- Reset mid-RUN (start din=0x04, assert rst_n=0 at cycle 3) -> all outputs 0 immediately; no done after release; a new start then completes normally.
- M=8, POLY=0x11B, SQ_PER_CYC=1: din=0x04 -> dout=0x02; 0x10 -> 0x04; 0x40 -> 0x08. done exactly 8 cycles after start, busy high for 7 cycles.
- Reduction path: din=0x1B -> dout=0x10; din=0x6C -> dout=0x20; din=0x00 -> 0x00; din=0x01 -> 0x01.
- Handshake: start held high with din changing while busy -> result matches the first captured din. Start asserted in the done cycle -> second operation accepted, dout from the first is held until the second done.
- SQ_PER_CYC=3 (remainder case, 7=3+3+1): din=0x6C -> dout=0x20 with done 4 cycles after start.
- Randomized 1000 operands with SQRT_SELFCHECK_EN -> model squarer(dout)==din for all, err stays 0, latency 9 cycles. Force an acc bit flip via bench -> err=1 on the done cycle, cleared on the next start.
